mdu_unit: RTL

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline; owns the HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo in one cycle; returns HI or LO for mfhi/mflo.
- Drives md_stall, which the hazard/stall unit gates with the D-stage md/mt/mf class to freeze the front end.
- A req input from the exception logic cancels side effects of the E-stage instruction.

---
 rtl/mdu_unit_if.sv | 22 ++
 rtl/mdu_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/mdu_unit_if.sv
// E-stage multiply/divide bus: operands and op code in, stall/busy/HI/LO/read data out.
interface mdu_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  md_op;
    logic        req;
    logic        md_stall;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    modport master (
        output A, B, md_op, req,
        input  md_stall, busy, HI, LO, md_out
    );

    modport slave (
        input  A, B, md_op, req,
        output md_stall, busy, HI, LO, md_out
    );
endinterface

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit: owns HI/LO, computes the result at issue and
// commits it after a fixed busy period so the pipeline sees fixed latency.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_md, is_mul, is_sdiv, start, busy_w;
    logic [63:0] sa, sb, prod_s, prod_u, result;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag, quo, rem;

    assign is_md   = (bus.md_op >= 4'd1) && (bus.md_op <= 4'd4);
    assign is_mul  = (bus.md_op == 4'd1) || (bus.md_op == 4'd2);
    assign is_sdiv = (bus.md_op == 4'd3);
    assign start   = is_md && !bus.req && (state_q == IDLE);

    // Products on sign-/zero-extended 64-bit operands; low 64 bits are exact.
    assign sa     = {{32{bus.A[31]}}, bus.A};
    assign sb     = {{32{bus.B[31]}}, bus.B};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide via magnitudes: avoids the INT_MIN/-1 overflow corner and
    // gives truncation toward zero with remainder taking the dividend's sign.
    assign a_neg = is_sdiv && bus.A[31];
    assign b_neg = is_sdiv && bus.B[31];
    assign a_mag = a_neg ? (32'd0 - bus.A) : bus.A;
    assign b_mag = b_neg ? (32'd0 - bus.B) : bus.B;
    assign dvs   = (bus.B == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / dvs;
    assign r_mag = a_mag % dvs;
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        case (bus.md_op)
            4'd1:    result = prod_s;
            4'd2:    result = prod_u;
            default: result = {rem, quo};
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = BUSY;
                    cnt_d     = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    pend_d    = result;
                    // Divide by zero still runs the full period but commits nothing.
                    pend_wr_d = is_mul || (bus.B != 32'd0);
                end else if (!bus.req) begin
                    if (bus.md_op == 4'd5) hi_d = bus.A;
                    if (bus.md_op == 4'd6) lo_d = bus.A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (pend_wr_q) {hi_d, lo_d} = pend_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_w       = (state_q == BUSY);
        bus.busy     = busy_w;
        bus.md_stall = start || busy_w;
        bus.HI       = hi_q;
        bus.LO       = lo_q;
        case (bus.md_op)
            4'd7:    bus.md_out = hi_q;
            4'd8:    bus.md_out = lo_q;
            default: bus.md_out = 32'd0;
        endcase
    end
endmodule
